// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle sequencer: FSM state codes,
// default exception vector and the next-PC selector.
package mc_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] FETCH  = 3'd0;
  localparam logic [STATE_W-1:0] DECODE = 3'd1;
  localparam logic [STATE_W-1:0] EXEC   = 3'd2;
  localparam logic [STATE_W-1:0] MEM    = 3'd3;
  localparam logic [STATE_W-1:0] WB     = 3'd4;
  localparam logic [STATE_W-1:0] EXC    = 3'd5;

  localparam int unsigned EXC_VEC_DEFAULT = 32'h0000_00F0;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_BRANCH,
    PC_JUMP,
    PC_VEC,
    PC_LOAD
  } pc_sel_e;

endpackage

// File: rtl/mc_pc_unit.sv
// Program counter register with its next-PC mux (increment, branch, jump,
// exception vector, switch load). All arithmetic wraps modulo 2^PC_W.
module mc_pc_unit
  import mc_pkg::*;
#(
  parameter int          PC_W    = 8,
  parameter int unsigned EXC_VEC = EXC_VEC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  pc_sel_e         sel,
  input  logic [PC_W-1:0] load_val,
  input  logic [PC_W-1:0] target,
  input  logic            alu_zero,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] VEC = PC_W'(EXC_VEC);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    pc_d = pc_q;
    case (sel)
      PC_INC:    pc_d = pc_inc;
      PC_BRANCH: pc_d = alu_zero ? (pc_inc + target) : pc_inc;
      PC_JUMP:   pc_d = target;
      PC_VEC:    pc_d = VEC;
      PC_LOAD:   pc_d = load_val;
      default:   pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle MIPS sequencer: FSM owning PC/IR, register and DMEM strobes,
// ack-stretched memory access with timeout, and exception vectoring with EPC.
// Optional single-step gating of FETCH via macro MC_SEQ_STEP_EN.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int          PC_W    = 8,
  parameter int unsigned EXC_VEC = EXC_VEC_DEFAULT,
  parameter int unsigned MEM_TMO = 15
) (
  input  logic                SYS_clk,
  input  logic                SYS_rst,
  input  logic                SYS_load,
`ifdef MC_SEQ_STEP_EN
  input  logic                SYS_step,
`endif
  input  logic [PC_W-1:0]     SYS_pc_val,
  input  logic [31:0]         IMEM_instruction,
  input  logic                dec_regw,
  input  logic                dec_mem_rd,
  input  logic                dec_mem_wr,
  input  logic                dec_branch,
  input  logic                dec_jump,
  input  logic                alu_zero,
  input  logic                exc_req,
  input  logic                dmem_ack,
  output logic [PC_W-1:0]     PC_current,
  output logic [31:0]         IR,
  output logic                reg_we,
  output logic                dmem_rd,
  output logic                dmem_wr,
  output logic [PC_W-1:0]     EPC,
  output logic                EH_active,
  output logic [STATE_W-1:0]  state
);

  localparam int CNT_W = $clog2(MEM_TMO + 2);

  logic [STATE_W-1:0] state_q, state_d;
  logic [31:0]        ir_q, ir_d;
  logic [PC_W-1:0]    epc_q, epc_d;
  logic               eh_q, eh_d;
  logic               reg_we_q, reg_we_d;
  logic               dmem_rd_q, dmem_rd_d;
  logic               dmem_wr_q, dmem_wr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               tmo_hit;
  logic               fetch_go;
  pc_sel_e            pc_sel;

`ifdef MC_SEQ_STEP_EN
  logic [1:0] step_sync_q, step_sync_d;
  logic       step_prev_q, step_prev_d;

  assign step_sync_d = {step_sync_q[0], SYS_step};
  assign step_prev_d = step_sync_q[1];
  assign fetch_go    = step_sync_q[1] & ~step_prev_q;

  always_ff @(posedge SYS_clk or posedge SYS_rst) begin
    if (SYS_rst) begin
      step_sync_q <= '0;
      step_prev_q <= 1'b0;
    end else begin
      step_sync_q <= step_sync_d;
      step_prev_q <= step_prev_d;
    end
  end
`else
  assign fetch_go = 1'b1;
`endif

  // cnt_q counts MEM cycles already spent; the timeout fires on the edge it would reach MEM_TMO
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign tmo_hit = (MEM_TMO != 0) && (cnt_inc == CNT_W'(MEM_TMO));

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    epc_d   = epc_q;
    eh_d    = eh_q;
    cnt_d   = '0;
    pc_sel  = PC_HOLD;
    case (state_q)
      FETCH: begin
        if (SYS_load) begin
          pc_sel = PC_LOAD;
          eh_d   = 1'b0;
        end else if (fetch_go) begin
          ir_d    = IMEM_instruction;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (exc_req) begin
          state_d = EXC;
        end else if (dec_jump) begin
          pc_sel  = PC_JUMP;
          state_d = FETCH;
        end else if (dec_branch) begin
          pc_sel  = PC_BRANCH;
          state_d = FETCH;
        end else if (dec_mem_rd || dec_mem_wr) begin
          state_d = MEM;
        end else if (dec_regw) begin
          state_d = WB;
        end else begin
          pc_sel  = PC_INC;
          state_d = FETCH;
        end
      end
      MEM: begin
        if (dmem_ack) begin
          if (dec_mem_rd) begin
            state_d = WB;
          end else begin
            pc_sel  = PC_INC;
            state_d = FETCH;
          end
        end else if (tmo_hit) begin
          state_d = EXC;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WB: begin
        pc_sel  = PC_INC;
        state_d = FETCH;
      end
      EXC: begin
        epc_d   = PC_current;
        pc_sel  = PC_VEC;
        eh_d    = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // Strobes are registered from the next state so each is high only in its own state
    reg_we_d  = (state_d == WB);
    dmem_rd_d = (state_d == MEM) && dec_mem_rd;
    dmem_wr_d = (state_d == MEM) && dec_mem_wr;
  end

  always_ff @(posedge SYS_clk or posedge SYS_rst) begin
    if (SYS_rst) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      epc_q     <= '0;
      eh_q      <= 1'b0;
      reg_we_q  <= 1'b0;
      dmem_rd_q <= 1'b0;
      dmem_wr_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      epc_q     <= epc_d;
      eh_q      <= eh_d;
      reg_we_q  <= reg_we_d;
      dmem_rd_q <= dmem_rd_d;
      dmem_wr_q <= dmem_wr_d;
      cnt_q     <= cnt_d;
    end
  end

  mc_pc_unit #(
    .PC_W    (PC_W),
    .EXC_VEC (EXC_VEC)
  ) u_pc (
    .clk      (SYS_clk),
    .rst      (SYS_rst),
    .sel      (pc_sel),
    .load_val (SYS_pc_val),
    .target   (ir_q[PC_W-1:0]),
    .alu_zero (alu_zero),
    .pc       (PC_current)
  );

  assign IR        = ir_q;
  assign EPC       = epc_q;
  assign EH_active = eh_q;
  assign reg_we    = reg_we_q;
  assign dmem_rd   = dmem_rd_q;
  assign dmem_wr   = dmem_wr_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: an 8-bit-PC instance plus a 4-bit-PC
// instance sharing stimulus, used for the PC wrap case.
module tb_mc_sequencer;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sys_load = 1'b0;
  logic [7:0]  pc_val = '0;
  logic [31:0] instr = '0;
  logic        dec_regw = 1'b0, dec_mem_rd = 1'b0, dec_mem_wr = 1'b0;
  logic        dec_branch = 1'b0, dec_jump = 1'b0;
  logic        alu_zero = 1'b0, exc_req = 1'b0, dmem_ack = 1'b0;

  logic [7:0]  pc, epc;
  logic [31:0] ir;
  logic        reg_we, dmem_rd, dmem_wr, eh_active;
  logic [2:0]  state;

  logic [3:0]  pc4, epc4;
  logic [31:0] ir4;
  logic        reg_we4, dmem_rd4, dmem_wr4, eh_active4;
  logic [2:0]  state4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_sequencer #(.PC_W(8), .MEM_TMO(15)) u_dut (
    .SYS_clk(clk), .SYS_rst(rst), .SYS_load(sys_load), .SYS_pc_val(pc_val),
    .IMEM_instruction(instr), .dec_regw(dec_regw), .dec_mem_rd(dec_mem_rd),
    .dec_mem_wr(dec_mem_wr), .dec_branch(dec_branch), .dec_jump(dec_jump),
    .alu_zero(alu_zero), .exc_req(exc_req), .dmem_ack(dmem_ack),
    .PC_current(pc), .IR(ir), .reg_we(reg_we), .dmem_rd(dmem_rd),
    .dmem_wr(dmem_wr), .EPC(epc), .EH_active(eh_active), .state(state)
  );

  mc_sequencer #(.PC_W(4), .MEM_TMO(15)) u_dut4 (
    .SYS_clk(clk), .SYS_rst(rst), .SYS_load(sys_load), .SYS_pc_val(pc_val[3:0]),
    .IMEM_instruction(instr), .dec_regw(dec_regw), .dec_mem_rd(dec_mem_rd),
    .dec_mem_wr(dec_mem_wr), .dec_branch(dec_branch), .dec_jump(dec_jump),
    .alu_zero(alu_zero), .exc_req(exc_req), .dmem_ack(dmem_ack),
    .PC_current(pc4), .IR(ir4), .reg_we(reg_we4), .dmem_rd(dmem_rd4),
    .dmem_wr(dmem_wr4), .EPC(epc4), .EH_active(eh_active4), .state(state4)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_dec(input logic [31:0] ins, input logic regw, input logic rd,
                         input logic wr, input logic br, input logic jmp);
    instr      = ins;
    dec_regw   = regw;
    dec_mem_rd = rd;
    dec_mem_wr = wr;
    dec_branch = br;
    dec_jump   = jmp;
  endtask

  task automatic do_load(input logic [7:0] v);
    pc_val   = v;
    sys_load = 1'b1;
    @(negedge clk);
    sys_load = 1'b0;
  endtask

  // Runs one instruction from FETCH until FETCH is seen again, acking DMEM in
  // the ack_after-th MEM cycle (0 = never) and tallying strobe cycles.
  task automatic run_instr(input int ack_after, output int cycles, output int rd_n,
                           output int wr_n, output int we_n, output int we_first);
    int mem_cyc;
    mem_cyc  = 0;
    cycles   = 0;
    rd_n     = 0;
    wr_n     = 0;
    we_n     = 0;
    we_first = 0;
    while (cycles < 64) begin
      @(negedge clk);
      cycles++;
      if (reg_we) begin
        we_n++;
        if (we_first == 0) we_first = cycles + 1;
      end
      if (dmem_rd) rd_n++;
      if (dmem_wr) wr_n++;
      if (state == MEM) begin
        mem_cyc++;
        dmem_ack = (ack_after != 0) && (mem_cyc == ack_after);
      end else begin
        dmem_ack = 1'b0;
      end
      if (state == FETCH) break;
    end
    dmem_ack = 1'b0;
    chk("back_to_fetch", {29'd0, state}, {29'd0, FETCH});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc, rd_n, wr_n, we_n, we_first;

    repeat (2) @(negedge clk);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_epc_eh", {23'd0, eh_active, epc}, 32'd0);
    chk("rst_strobes", {29'd0, reg_we, dmem_rd, dmem_wr}, 32'd0);
    rst = 1'b0;

    // ALU op
    set_dec(32'h1234_5601, 1, 0, 0, 0, 0);
    run_instr(0, cyc, rd_n, wr_n, we_n, we_first);
    chk("alu_cycles", cyc, 32'd4);
    chk("alu_we_count", we_n, 32'd1);
    chk("alu_we_cycle", we_first, 32'd4);
    chk("alu_pc", {24'd0, pc}, 32'd1);
    chk("alu_ir", ir, 32'h1234_5601);

    // Load, ack in third MEM cycle
    set_dec(32'h8C00_0004, 1, 1, 0, 0, 0);
    run_instr(3, cyc, rd_n, wr_n, we_n, we_first);
    chk("ld_rd_cycles", rd_n, 32'd3);
    chk("ld_we_count", we_n, 32'd1);
    chk("ld_cycles", cyc, 32'd7);
    chk("ld_pc", {24'd0, pc}, 32'd2);

    // Store, ack in second MEM cycle
    set_dec(32'hAC00_0008, 0, 0, 1, 0, 0);
    run_instr(2, cyc, rd_n, wr_n, we_n, we_first);
    chk("st_wr_cycles", wr_n, 32'd2);
    chk("st_cycles", cyc, 32'd5);
    chk("st_pc", {24'd0, pc}, 32'd3);

    // Branch taken / not taken from 0x10
    do_load(8'h10);
    chk("load_pc", {24'd0, pc}, 32'h10);
    set_dec(32'h1000_0005, 0, 0, 0, 1, 0);
    alu_zero = 1'b1;
    run_instr(0, cyc, rd_n, wr_n, we_n, we_first);
    chk("br_taken_pc", {24'd0, pc}, 32'h16);
    chk("br_cycles", cyc, 32'd3);
    do_load(8'h10);
    alu_zero = 1'b0;
    run_instr(0, cyc, rd_n, wr_n, we_n, we_first);
    chk("br_not_taken_pc", {24'd0, pc}, 32'h11);
    chk("br_strobes", rd_n + wr_n + we_n, 32'd0);

    // Exception in EXEC at 0x22
    do_load(8'h22);
    set_dec(32'h0000_0000, 1, 0, 0, 0, 0);
    exc_req = 1'b1;
    run_instr(0, cyc, rd_n, wr_n, we_n, we_first);
    exc_req = 1'b0;
    chk("exc_cycles", cyc, 32'd4);
    chk("exc_epc", {24'd0, epc}, 32'h22);
    chk("exc_pc", {24'd0, pc}, 32'hF0);
    chk("exc_eh", {31'd0, eh_active}, 32'd1);
    chk("exc_strobes", rd_n + wr_n + we_n, 32'd0);
    do_load(8'h00);
    chk("clr_eh", {31'd0, eh_active}, 32'd0);
    chk("clr_pc", {24'd0, pc}, 32'd0);

    // Store with no ack: timeout after 15 MEM cycles
    set_dec(32'hAC00_0010, 0, 0, 1, 0, 0);
    run_instr(0, cyc, rd_n, wr_n, we_n, we_first);
    chk("tmo_wr_cycles", wr_n, 32'd15);
    chk("tmo_cycles", cyc, 32'd19);
    chk("tmo_epc", {24'd0, epc}, 32'd0);
    chk("tmo_pc", {24'd0, pc}, 32'hF0);
    chk("tmo_eh", {31'd0, eh_active}, 32'd1);
    chk("tmo_wr_low", {31'd0, dmem_wr}, 32'd0);

    // Jump to 0xF then ALU op: 4-bit PC wraps to 0
    set_dec(32'h0800_000F, 0, 0, 0, 0, 1);
    run_instr(0, cyc, rd_n, wr_n, we_n, we_first);
    chk("jmp_pc", {24'd0, pc}, 32'h0F);
    chk("jmp_pc4", {28'd0, pc4}, 32'hF);
    set_dec(32'h0000_0020, 1, 0, 0, 0, 0);
    run_instr(0, cyc, rd_n, wr_n, we_n, we_first);
    chk("alu_after_jmp_pc", {24'd0, pc}, 32'h10);
    chk("wrap_pc4", {28'd0, pc4}, 32'h0);
    do_load(8'hFF);
    chk("load_ff_eh", {31'd0, eh_active}, 32'd0);
    run_instr(0, cyc, rd_n, wr_n, we_n, we_first);
    chk("wrap_pc8", {24'd0, pc}, 32'h00);

    // Reset asserted mid-MEM drops the write request at once
    set_dec(32'hAC00_0030, 0, 0, 1, 0, 0);
    for (int i = 0; i < 10 && state != MEM; i++) @(negedge clk);
    @(negedge clk);
    chk("pre_rst_wr", {31'd0, dmem_wr}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_mem_wr", {31'd0, dmem_wr}, 32'd0);
    chk("rst_mid_mem_state", {29'd0, state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
